sram_port_arbiter: RTL and testbench

// - Shares one sram-like memory port between the core's inst_sram (m0) and data_sram (m1) interfaces.
// - Sits between mycpu_core and the sram-to-AXI bridge, so the bridge sees a single requester.
// - Arbitrates the address phase with data priority and a hold lock.
// - Records the owner of every accepted request in order, and routes each s_data_ok/s_rdata back to that owner.

---
 rtl/sram_port_arbiter.sv | 110 +++++++++++
 tb/tb_sram_port_arbiter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// Merges the inst (m0) and data (m1) sram-like ports into one request stream.
// Data has priority, and a stalled request keeps the port until it is accepted. Responses go back to owners in order.
module sram_port_arbiter #(
  parameter int OUTST = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m0_req,
  input  logic        m0_wr,
  input  logic [1:0]  m0_size,
  input  logic [3:0]  m0_wstrb,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_addr_ok,
  output logic        m0_data_ok,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_wr,
  input  logic [1:0]  m1_size,
  input  logic [3:0]  m1_wstrb,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_addr_ok,
  output logic        m1_data_ok,
  output logic [31:0] m1_rdata,
  output logic        s_req,
  output logic        s_wr,
  output logic [1:0]  s_size,
  output logic [3:0]  s_wstrb,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic        s_addr_ok,
  input  logic        s_data_ok,
  input  logic [31:0] s_rdata
);
  // state  | meaning
  // IDLE   | no stalled request; m1 wins if it requests, otherwise m0
  // LOCK_I | m0 was presented and not accepted; it keeps the port
  // LOCK_D | m1 was presented and not accepted; it keeps the port
  typedef enum logic [1:0] {IDLE, LOCK_I, LOCK_D} state_t;

  localparam int PW = $clog2(OUTST);
  localparam int CW = PW + 1;

  state_t          state, state_nxt;
  logic [OUTST-1:0] owner_q;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   cnt;
  logic            full, sel_m1, sel_req, accept, pop, head_m1;

  always_comb begin
    sel_m1  = (state == LOCK_D) || ((state == IDLE) && m1_req);
    sel_req = sel_m1 ? m1_req : m0_req;
    full    = (cnt == CW'(OUTST));
    s_req   = resetn & sel_req & ~full;
    accept  = s_req & s_addr_ok;
    s_wr    = 1'b0;
    s_size  = '0;
    s_wstrb = '0;
    s_addr  = '0;
    s_wdata = '0;
    if (resetn && sel_req) begin
      s_wr    = sel_m1 ? m1_wr    : m0_wr;
      s_size  = sel_m1 ? m1_size  : m0_size;
      s_wstrb = sel_m1 ? m1_wstrb : m0_wstrb;
      s_addr  = sel_m1 ? m1_addr  : m0_addr;
      s_wdata = sel_m1 ? m1_wdata : m0_wdata;
    end
    m0_addr_ok = accept & ~sel_m1;
    m1_addr_ok = accept & sel_m1;
    // A response with nothing outstanding is dropped.
    pop        = resetn & s_data_ok & (cnt != '0);
    head_m1    = owner_q[rd_ptr];
    m0_data_ok = pop & ~head_m1;
    m1_data_ok = pop & head_m1;
    m0_rdata   = resetn ? s_rdata : '0;
    m1_rdata   = resetn ? s_rdata : '0;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:           if (sel_req && !accept) state_nxt = sel_m1 ? LOCK_D : LOCK_I;
      LOCK_I, LOCK_D: if (accept) state_nxt = IDLE;
      default:        state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      owner_q <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        owner_q[wr_ptr] <= sel_m1;
        wr_ptr          <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({accept, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Randomized bench: two request generators, an in-order slave model and a transaction-level
// reference (owner of each accepted request, priority/hold rule, outstanding limit).
module tb_sram_port_arbiter;
  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;
  typedef struct {
    bit          m;
    logic [31:0] rdata;
  } sresp_t;

  logic clk = 1'b0, resetn = 1'b0;
  logic m0_req = 1'b0, m1_req = 1'b0;
  logic m0_addr_ok, m0_data_ok, m1_addr_ok, m1_data_ok;
  logic [31:0] m0_rdata, m1_rdata;
  logic s_req, s_wr;
  logic [1:0] s_size;
  logic [3:0] s_wstrb;
  logic [31:0] s_addr, s_wdata;
  logic s_addr_ok = 1'b0, s_data_ok = 1'b0;
  logic [31:0] s_rdata = '0;

  req_t rq0 = '0, rq1 = '0;
  bit pend0 = 0, pend1 = 0;
  int seq0 = 0, seq1 = 0;
  int lock_own = -1;
  int outstanding = 0;
  int passed = 0, total = 0;
  int full_seen = 0, both_seen = 0, empty_pop_seen = 0;
  sresp_t slave_q[$];
  logic [31:0] exp0_q[$], exp1_q[$];

  sram_port_arbiter #(.OUTST(4)) dut (
    .clk(clk), .resetn(resetn),
    .m0_req(m0_req), .m0_wr(rq0.wr), .m0_size(rq0.size), .m0_wstrb(rq0.wstrb),
    .m0_addr(rq0.addr), .m0_wdata(rq0.wdata),
    .m0_addr_ok(m0_addr_ok), .m0_data_ok(m0_data_ok), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_wr(rq1.wr), .m1_size(rq1.size), .m1_wstrb(rq1.wstrb),
    .m1_addr(rq1.addr), .m1_wdata(rq1.wdata),
    .m1_addr_ok(m1_addr_ok), .m1_data_ok(m1_data_ok), .m1_rdata(m1_rdata),
    .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_wstrb(s_wstrb),
    .s_addr(s_addr), .s_wdata(s_wdata),
    .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] resp_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  // Reference model and bus checks, evaluated mid-cycle before the next rising edge.
  always @(negedge clk) begin : monitor
    bit sel, sreq_sel, exp_sreq, acc, popv;
    req_t r;
    if (!resetn) begin
      chk("rst_s_req", 32'(s_req), 32'd0);
      chk("rst_s_bus", {25'd0, s_wr, s_size, s_wstrb} | s_addr | s_wdata, 32'd0);
      chk("rst_ok", {28'd0, m0_addr_ok, m1_addr_ok, m0_data_ok, m1_data_ok}, 32'd0);
      chk("rst_rdata", m0_rdata | m1_rdata, 32'd0);
      slave_q.delete(); exp0_q.delete(); exp1_q.delete();
      outstanding = 0; lock_own = -1; pend0 = 0; pend1 = 0;
    end else begin
      sel      = (lock_own >= 0) ? (lock_own == 1) : pend1;
      sreq_sel = sel ? pend1 : pend0;
      exp_sreq = sreq_sel && (outstanding < 4);
      r        = sel ? rq1 : rq0;
      if (sreq_sel && outstanding == 4) full_seen++;
      if (pend0 && pend1 && lock_own < 0) both_seen++;
      chk("s_req", 32'(s_req), 32'(exp_sreq));
      if (sreq_sel) begin
        chk("s_addr", s_addr, r.addr);
        chk("s_ctl", {25'd0, s_wr, s_size, s_wstrb}, {25'd0, r.wr, r.size, r.wstrb});
        chk("s_wdata", s_wdata, r.wdata);
      end else begin
        chk("s_bus_idle", {25'd0, s_wr, s_size, s_wstrb} | s_addr | s_wdata, 32'd0);
      end
      acc  = exp_sreq && s_addr_ok;
      popv = s_data_ok && (slave_q.size() > 0);
      if (s_data_ok && slave_q.size() == 0) empty_pop_seen++;
      chk("m0_addr_ok", 32'(m0_addr_ok), 32'(acc && !sel));
      chk("m1_addr_ok", 32'(m1_addr_ok), 32'(acc && sel));
      chk("m0_data_ok", 32'(m0_data_ok), 32'(popv && !slave_q[0].m));
      chk("m1_data_ok", 32'(m1_data_ok), 32'(popv && slave_q[0].m));
      if (acc) begin
        slave_q.push_back('{m: sel, rdata: resp_of(r.addr)});
        if (sel) begin exp1_q.push_back(resp_of(r.addr)); pend1 = 0; end
        else     begin exp0_q.push_back(resp_of(r.addr)); pend0 = 0; end
      end
      if (acc) lock_own = -1;
      else if (sreq_sel) lock_own = sel ? 1 : 0;
      if (popv) void'(slave_q.pop_front());
      outstanding = outstanding + int'(acc) - int'(popv);
    end
  end

  // Response scoreboard: each master must get its own responses, in order.
  always @(negedge clk) begin : scoreboard
    if (resetn && m0_data_ok) begin
      chk("m0_rsp_expected", 32'(exp0_q.size() > 0), 32'd1);
      if (exp0_q.size() > 0) chk("m0_rdata", m0_rdata, exp0_q.pop_front());
    end
    if (resetn && m1_data_ok) begin
      chk("m1_rsp_expected", 32'(exp1_q.size() > 0), 32'd1);
      if (exp1_q.size() > 0) chk("m1_rdata", m1_rdata, exp1_q.pop_front());
    end
  end

  task automatic run(input int n, input int pn0, input int pn1, input int pa, input int pd);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (!pend0 && int'($urandom_range(99)) < pn0) begin
        rq0.wr = 1'($urandom); rq0.size = 2'($urandom_range(2)); rq0.wstrb = 4'($urandom);
        rq0.addr = 32'h1c00_0000 + 32'(seq0 << 2); rq0.wdata = $urandom;
        seq0++; pend0 = 1;
      end
      if (!pend1 && int'($urandom_range(99)) < pn1) begin
        rq1.wr = 1'($urandom); rq1.size = 2'($urandom_range(2)); rq1.wstrb = 4'($urandom);
        rq1.addr = 32'h8000_0000 + 32'(seq1 << 2); rq1.wdata = $urandom;
        seq1++; pend1 = 1;
      end
      m0_req    = pend0;
      m1_req    = pend1;
      s_addr_ok = int'($urandom_range(99)) < pa;
      s_data_ok = int'($urandom_range(99)) < pd;
      s_rdata   = (s_data_ok && slave_q.size() > 0) ? slave_q[0].rdata : $urandom;
    end
  endtask

  initial begin
    int guard;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    run(20, 100, 0, 100, 100);      // m0 alone
    run(40, 100, 100, 100, 50);     // both masters, data priority
    run(2, 100, 0, 0, 0);           // m0 stalled ...
    run(3, 100, 100, 0, 0);         // ... m1 arrives but must wait
    run(10, 100, 100, 100, 0);      // fill to the outstanding limit
    run(10, 100, 100, 100, 40);     // drain while still requesting
    run(2000, 60, 60, 70, 45);
    guard = 0;
    while (outstanding != 3 && guard < 50) begin
      run(1, 100, 100, 100, 0);
      guard++;
    end
    chk("reach_cnt3", 32'(outstanding), 32'd3);
    resetn = 1'b0;                  // asynchronous, mid-cycle, with traffic in flight
    run(3, 0, 0, 0, 0);
    @(posedge clk); #1 resetn = 1'b1;
    run(5, 0, 0, 0, 100);           // stray responses with nothing outstanding
    run(1000, 50, 70, 60, 50);
    run(60, 0, 0, 100, 100);        // drain
    chk("m0_rsp_left", 32'(exp0_q.size()), 32'd0);
    chk("m1_rsp_left", 32'(exp1_q.size()), 32'd0);
    chk("seen_full", 32'(full_seen > 0), 32'd1);
    chk("seen_both", 32'(both_seen > 0), 32'd1);
    chk("seen_empty_pop", 32'(empty_pop_seen > 0), 32'd1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
